// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: default widths,
// access-counter width and the sequencer state encoding.
package mem_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, and on a
// tie the master that was not granted last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    assign valid = |req;
    assign sel   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter and sequencer for the single-port system memory: grants
// one master at a time, holds the strobes for a fixed window, then ACKs.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int ADDR_WIDTH    = ADDR_W,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  M0_REQ,
    input  logic                  M0_WE,
    input  logic [ADDR_WIDTH-1:0] M0_ADDR,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    output logic                  M0_ACK,
    input  logic                  M1_REQ,
    input  logic                  M1_WE,
    input  logic [ADDR_WIDTH-1:0] M1_ADDR,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic                  M1_ACK,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  GRANT,
    output logic                  BUSY
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  last_ptr, last_next;
    logic                  grant_q, grant_next;
    logic                  we_q, we_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_next;
    logic                  read_q, read_next;
    logic                  write_q, write_next;
    logic                  ack0_q, ack0_next;
    logic                  ack1_q, ack1_next;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_next;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_next;
    logic                  pick_valid;
    logic                  pick_sel;
    logic                  sel_we;

    rr_pick2 u_pick (
        .req   ({M1_REQ, M0_REQ}),
        .last  (last_ptr),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    assign sel_we = pick_sel ? M1_WE : M0_WE;

    // Every output is a flop, so an asserted reset clears the strobes at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last_ptr <= 1'b1;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            last_ptr <= last_next;
            grant_q  <= grant_next;
            we_q     <= we_next;
            addr_q   <= addr_next;
            wdata_q  <= wdata_next;
            read_q   <= read_next;
            write_q  <= write_next;
            ack0_q   <= ack0_next;
            ack1_q   <= ack1_next;
            rdata0_q <= rdata0_next;
            rdata1_q <= rdata1_next;
        end
    end

    // Strobes and ACK are computed one cycle early so they come straight from flops.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        last_next   = last_ptr;
        grant_next  = grant_q;
        we_next     = we_q;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        read_next   = 1'b0;
        write_next  = 1'b0;
        ack0_next   = 1'b0;
        ack1_next   = 1'b0;
        rdata0_next = rdata0_q;
        rdata1_next = rdata1_q;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_sel;
                    last_next  = pick_sel;
                    we_next    = sel_we;
                    addr_next  = pick_sel ? M1_ADDR : M0_ADDR;
                    wdata_next = pick_sel ? M1_WDATA : M0_WDATA;
                    cnt_next   = CNT_LOAD;
                    read_next  = ~sel_we;
                    write_next = sel_we;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_next   = cnt - 1'b1;
                    read_next  = ~we_q;
                    write_next = we_q;
                end else begin
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_next = MEM_RDATA;
                        end else begin
                            rdata0_next = MEM_RDATA;
                        end
                    end
                    ack0_next  = ~grant_q;
                    ack1_next  = grant_q;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign MEM_READ  = read_q;
    assign MEM_WRITE = write_q;
    assign M0_ACK    = ack0_q;
    assign M1_ACK    = ack1_q;
    assign M0_RDATA  = rdata0_q;
    assign M1_RDATA  = rdata1_q;
    assign GRANT     = grant_q;
    assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, reset abort sequence and
// randomized traffic checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [25:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [25:0] mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        grant, busy;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(26), .ACCESS_CYCLES(N)) dut (
        .CLK(clk), .RST(rst),
        .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
        .M0_RDATA(m0_rdata), .M0_ACK(m0_ack),
        .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
        .M1_RDATA(m1_rdata), .M1_ACK(m1_ack),
        .MEM_ADDR(mem_addr), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
        .GRANT(grant), .BUSY(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req0;
        logic        we0;
        logic [25:0] addr0;
        logic [31:0] wd0;
        logic        req1;
        logic        we1;
        logic [25:0] addr1;
        logic [31:0] wd1;
        logic        exp_grant;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic        drop;
    } vec_t;

    int total = 0;
    int bad = 0;

    function automatic logic [25:0] addr_of(input int i);
        case (i)
            0: return 26'h0004000;
            1: return 26'h0048000;
            2: return 26'h3FFFFFF;
            3: return 26'h0000000;
            4: return 26'h0000001;
            5: return 26'h1234567;
            6: return 26'h2AAAAAA;
            default: return 26'h3FFFFFE;
        endcase
    endfunction

    function automatic logic [31:0] mem_init(input int i);
        case (i)
            0: return 32'hDEADBEEF;
            3: return 32'h01010101;
            4: return 32'h11111111;
            5: return 32'h76543210;
            6: return 32'h55555555;
            7: return 32'hFEEDFACE;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic int idx_of(input logic [25:0] a);
        for (int i = 0; i < 8; i++) begin
            if (addr_of(i) == a) return i;
        end
        return 8;
    endfunction

    // Memory environment: eight known locations, anything else reads a marker.
    logic [31:0] wr_tab [8];
    logic [7:0]  wr_valid = '0;

    function automatic logic [31:0] env_read(input logic [25:0] a);
        int i;
        i = idx_of(a);
        if (i > 7) return 32'h0BAD0BAD;
        return wr_valid[i] ? wr_tab[i] : mem_init(i);
    endfunction

    always @(posedge clk) begin
        if (mem_write && idx_of(mem_addr) < 8) begin
            wr_tab[idx_of(mem_addr)]   <= mem_wdata;
            wr_valid[idx_of(mem_addr)] <= 1'b1;
        end
    end

    always @(negedge clk) mem_rdata <= env_read(mem_addr);

    // Reference model: memory image, both read-data registers, last winner.
    logic [31:0] ref_mem [8];
    logic [31:0] ref_rd [2];
    logic        ref_last;

    task automatic modelCommit(input logic w, input logic we, input logic [25:0] a, input logic [31:0] wd);
        if (we) ref_mem[idx_of(a)] = wd;
        else ref_rd[w] = ref_mem[idx_of(a)];
        ref_last = w;
    endtask

    task automatic commitVec(input vec_t v);
        if (v.exp_grant) modelCommit(1'b1, v.we1, v.addr1, v.wd1);
        else modelCommit(1'b0, v.we0, v.addr0, v.wd0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        m0_req = v.req0; m0_we = v.we0; m0_addr = v.addr0; m0_wdata = v.wd0;
        m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr1; m1_wdata = v.wd1;
    endtask

    // Called at the falling edge of an idle cycle; returns at the falling edge
    // of the idle cycle that follows the ACK.
    task automatic doTxn(input vec_t v, input string tag);
        logic        w_we;
        logic [25:0] w_addr;
        logic [31:0] w_wd;
        w_we   = v.exp_grant ? v.we1 : v.we0;
        w_addr = v.exp_grant ? v.addr1 : v.addr0;
        w_wd   = v.exp_grant ? v.wd1 : v.wd0;
        applyStimulus(v);
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            checkOutput({tag, " grant"}, 32'(grant), 32'(v.exp_grant));
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " mem_read"}, 32'(mem_read), 32'(!w_we));
            checkOutput({tag, " mem_write"}, 32'(mem_write), 32'(w_we));
            checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(w_addr));
            if (w_we) checkOutput({tag, " mem_wdata"}, mem_wdata, w_wd);
            checkOutput({tag, " early ack"}, 32'({m1_ack, m0_ack}), 32'd0);
            if (c == 1 && v.drop) begin
                if (v.exp_grant) begin
                    m1_req = 1'b0; m1_addr = ~m1_addr; m1_wdata = ~m1_wdata;
                end else begin
                    m0_req = 1'b0; m0_addr = ~m0_addr; m0_wdata = ~m0_wdata;
                end
            end
        end
        @(negedge clk);
        checkOutput({tag, " m0_ack"}, 32'(m0_ack), 32'(!v.exp_grant));
        checkOutput({tag, " m1_ack"}, 32'(m1_ack), 32'(v.exp_grant));
        checkOutput({tag, " done strobes"}, 32'({mem_read, mem_write}), 32'd0);
        checkOutput({tag, " done busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " m0_rdata"}, m0_rdata, v.exp_rd0);
        checkOutput({tag, " m1_rdata"}, m1_rdata, v.exp_rd1);
        @(negedge clk);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle ack"}, 32'({m1_ack, m0_ack}), 32'd0);
        checkOutput({tag, " idle strobes"}, 32'({mem_read, mem_write}), 32'd0);
    endtask

    vec_t        vecs [12];
    vec_t        v;
    logic        p [2];
    logic        c_we [2];
    logic [25:0] c_addr [2];
    logic [31:0] c_wd [2];
    logic        w;

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = mem_init(i);
        ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1'b1;

        //           r0   we0  addr0         wd0            r1   we1  addr1         wd1            g    rd0            rd1            drop
        vecs[0]  = '{1'b1,1'b0,26'h0004000,32'h0,        1'b0,1'b0,26'h0,      32'h0,        1'b0,32'hDEADBEEF,32'h0,        1'b0};
        vecs[1]  = '{1'b0,1'b0,26'h0,      32'h0,        1'b1,1'b1,26'h0048000,32'h12345678, 1'b1,32'hDEADBEEF,32'h0,        1'b0};
        vecs[2]  = '{1'b1,1'b0,26'h0048000,32'h0,        1'b1,1'b0,26'h0004000,32'h0,        1'b0,32'h12345678,32'h0,        1'b0};
        vecs[3]  = '{1'b1,1'b1,26'h3FFFFFF,32'hA5A5A5A5, 1'b1,1'b0,26'h0004000,32'h0,        1'b1,32'h12345678,32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1,1'b1,26'h3FFFFFF,32'hA5A5A5A5, 1'b1,1'b0,26'h0000001,32'h0,        1'b0,32'h12345678,32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1,1'b0,26'h3FFFFFF,32'h0,        1'b1,1'b0,26'h0000001,32'h0,        1'b1,32'h12345678,32'h11111111, 1'b0};
        vecs[6]  = '{1'b1,1'b0,26'h3FFFFFF,32'h0,        1'b1,1'b1,26'h0000000,32'hCAFEF00D, 1'b0,32'hA5A5A5A5,32'h11111111, 1'b0};
        vecs[7]  = '{1'b1,1'b1,26'h3FFFFFE,32'h5A5A5A5A, 1'b1,1'b1,26'h0000000,32'hCAFEF00D, 1'b1,32'hA5A5A5A5,32'h11111111, 1'b0};
        vecs[8]  = '{1'b1,1'b1,26'h3FFFFFE,32'h5A5A5A5A, 1'b0,1'b0,26'h0,      32'h0,        1'b0,32'hA5A5A5A5,32'h11111111, 1'b0};
        vecs[9]  = '{1'b1,1'b0,26'h0000000,32'h0,        1'b1,1'b0,26'h3FFFFFE,32'h0,        1'b1,32'hA5A5A5A5,32'h5A5A5A5A, 1'b0};
        vecs[10] = '{1'b1,1'b0,26'h0000000,32'h0,        1'b0,1'b0,26'h0,      32'h0,        1'b0,32'hCAFEF00D,32'h5A5A5A5A, 1'b1};
        vecs[11] = '{1'b0,1'b0,26'h0,      32'h0,        1'b1,1'b0,26'h1234567,32'h0,        1'b1,32'hCAFEF00D,32'h76543210, 1'b1};

        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset grant", 32'(grant), 32'd0);
        checkOutput("reset acks", 32'({m1_ack, m0_ack}), 32'd0);
        checkOutput("reset m0_rdata", m0_rdata, 32'd0);
        checkOutput("reset m1_rdata", m1_rdata, 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            commitVec(vecs[i]);
            doTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the second access cycle of a read granted to master 0.
        v = '{1'b1,1'b0,26'h0000001,32'h0, 1'b0,1'b0,26'h0,32'h0, 1'b0,32'h0,32'h0, 1'b0};
        applyStimulus(v);
        @(negedge clk);
        checkOutput("abort pre read", 32'(mem_read), 32'd1);
        @(negedge clk);
        checkOutput("abort pre busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort mem_read", 32'(mem_read), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort grant", 32'(grant), 32'd0);
        checkOutput("abort m0_rdata", m0_rdata, 32'd0);
        checkOutput("abort m1_rdata", m1_rdata, 32'd0);
        v = '{1'b1,1'b0,26'h0048000,32'h0, 1'b1,1'b0,26'h3FFFFFE,32'h0, 1'b0,32'h12345678,32'h0, 1'b0};
        applyStimulus(v);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort no ack", 32'({m1_ack, m0_ack}), 32'd0);
        checkOutput("abort held strobes", 32'({mem_read, mem_write}), 32'd0);
        rst = 1'b1;
        ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1'b1;
        commitVec(v);
        doTxn(v, "post-reset tie");
        v = '{1'b0,1'b0,26'h0,32'h0, 1'b1,1'b0,26'h3FFFFFE,32'h0, 1'b1,32'h12345678,32'h5A5A5A5A, 1'b0};
        commitVec(v);
        doTxn(v, "post-reset m1");

        p[0] = 1'b0; p[1] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p[m] && $urandom_range(0, 1) == 1) begin
                    p[m] = 1'b1;
                    c_we[m] = 1'($urandom_range(0, 1));
                    c_addr[m] = addr_of($urandom_range(0, 7));
                    c_wd[m] = $urandom;
                end
            end
            if (!p[0] && !p[1]) begin
                m0_req = 1'b0; m1_req = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    checkOutput("rnd idle busy", 32'(busy), 32'd0);
                    checkOutput("rnd idle strobes", 32'({mem_read, mem_write}), 32'd0);
                end
                p[t % 2] = 1'b1;
                c_we[t % 2] = 1'($urandom_range(0, 1));
                c_addr[t % 2] = addr_of($urandom_range(0, 7));
                c_wd[t % 2] = $urandom;
            end
            w = (p[0] && p[1]) ? !ref_last : p[1];
            modelCommit(w, c_we[w], c_addr[w], c_wd[w]);
            v = '{p[0], c_we[0], c_addr[0], c_wd[0], p[1], c_we[1], c_addr[1], c_wd[1],
                  w, ref_rd[0], ref_rd[1], 1'($urandom_range(0, 3) == 0)};
            doTxn(v, $sformatf("rnd%0d", t));
            p[w] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
